// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared encodings for the hazard scoreboard
package hazard_scoreboard_pkg;
    localparam logic [1:0] SEL_MEM_AS_RES = 2'b01;
    typedef enum logic [1:0] {
        HZ_RUN       = 2'd0,
        HZ_IMEM_WAIT = 2'd1,
        HZ_DMEM_WAIT = 2'd2,
        HZ_REDIRECT  = 2'd3
    } hz_state_t;
    typedef struct packed {
        logic stall_pc_if;
        logic stall_if_id;
        logic flush_if_id;
        logic flush_id_ex;
    } hz_ctrl_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: pipeline-side bundle between pipeline registers and the hazard unit
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int CW = 3
);
    logic            inst_mem_hazard;
    logic            data_mem_hazard;
    logic [AW-1:0]   rs1_ID;
    logic [AW-1:0]   rs2_ID;
    logic            rs1_used_ID;
    logic            rs2_used_ID;
    logic [AW-1:0]   rd_EX;
    logic [1:0]      result_sel_EX;
    logic            load_issue_MEM;
    logic [AW-1:0]   rd_MEM;
    logic            load_done_WB;
    logic [AW-1:0]   rd_WB;
    logic            PC_take_branch_EX;
    logic            PC_take_jalr_EX;
    logic            stall_PC_IF;
    logic            stall_IF_ID;
    logic            flush_IF_ID;
    logic            flush_ID_EX;
    logic [2**AW-1:0] busy_vec;
    logic [CW-1:0]   pending_cnt;
    modport master (
        output inst_mem_hazard, data_mem_hazard, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
               rd_EX, result_sel_EX, load_issue_MEM, rd_MEM, load_done_WB, rd_WB,
               PC_take_branch_EX, PC_take_jalr_EX,
        input  stall_PC_IF, stall_IF_ID, flush_IF_ID, flush_ID_EX, busy_vec, pending_cnt
    );
    modport slave (
        input  inst_mem_hazard, data_mem_hazard, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
               rd_EX, result_sel_EX, load_issue_MEM, rd_MEM, load_done_WB, rd_WB,
               PC_take_branch_EX, PC_take_jalr_EX,
        output stall_PC_IF, stall_IF_ID, flush_IF_ID, flush_ID_EX, busy_vec, pending_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// reg_scoreboard: per-register busy bits and saturating outstanding-load counter
module reg_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW          = 5,
    parameter int MAX_PENDING = 4,
    parameter int CW          = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [AW-1:0]    rd_issue,
    input  logic             done,
    input  logic [AW-1:0]    rd_done,
    output logic [2**AW-1:0] busy,
    output logic [CW-1:0]    cnt
);
    localparam int N = 2**AW;
    logic [N-1:0] set, clr;
    logic         full, empty;
    always_comb begin
        set   = (issue && rd_issue != '0) ? N'(1) << rd_issue : '0;
        clr   = done ? N'(1) << rd_done : '0;
        full  = cnt == CW'(MAX_PENDING);
        empty = cnt == '0;
    end
    // set is OR-ed after the clear so a newer load to the same register wins
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= ((busy & ~clr) | set) & ~N'(1);
            cnt  <= (issue && !done && !full) ? cnt + CW'(1) :
                    (done && !issue && !empty) ? cnt - CW'(1) : cnt;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/flush control with load scoreboard, memory-wait FSM and redirect latch
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_events counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int MAX_PENDING         = 4,
    parameter int CNT_WIDTH           = $clog2(MAX_PENDING + 1)
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);
    localparam int N = 2**REGISTER_ADDR_WIDTH;
    hz_state_t            state, state_d;
    hz_ctrl_t             ctrl;
    logic                 latch, latch_d;
    logic                 waiting, redir, ld_ex, dep;
    logic [N-1:0]         busy;
    logic [CNT_WIDTH-1:0] cnt;

    reg_scoreboard #(
        .AW(REGISTER_ADDR_WIDTH),
        .MAX_PENDING(MAX_PENDING),
        .CW(CNT_WIDTH)
    ) u_sb (
        .clk(clk),
        .rst(rst),
        .issue(hz.load_issue_MEM),
        .rd_issue(hz.rd_MEM),
        .done(hz.load_done_WB),
        .rd_done(hz.rd_WB),
        .busy(busy),
        .cnt(cnt)
    );

    assign hz.busy_vec    = busy;
    assign hz.pending_cnt = cnt;

    always_ff @(posedge clk) begin
        state <= rst ? HZ_RUN : state_d;
        latch <= rst ? 1'b0 : latch_d;
    end

    // a redirect seen on the final wait cycle still routes through REDIRECT
    always_comb begin
        redir   = hz.PC_take_branch_EX | hz.PC_take_jalr_EX;
        waiting = state == HZ_IMEM_WAIT || state == HZ_DMEM_WAIT;
        latch_d = state == HZ_REDIRECT ? 1'b0 : latch | (waiting & redir);
        state_d = (hz.data_mem_hazard && state != HZ_REDIRECT) ? HZ_DMEM_WAIT :
                  state == HZ_REDIRECT                       ? HZ_RUN :
                  state == HZ_RUN                            ? (hz.inst_mem_hazard ? HZ_IMEM_WAIT : HZ_RUN) :
                  (state == HZ_IMEM_WAIT && hz.inst_mem_hazard) ? HZ_IMEM_WAIT :
                  latch_d                                    ? HZ_REDIRECT : HZ_RUN;
    end

    always_comb begin
        ld_ex = hz.result_sel_EX == SEL_MEM_AS_RES;
        dep   = (hz.rs1_used_ID && busy[hz.rs1_ID]) ||
                (hz.rs2_used_ID && busy[hz.rs2_ID]) ||
                (ld_ex && hz.rd_EX != '0 &&
                 ((hz.rs1_used_ID && hz.rd_EX == hz.rs1_ID) || (hz.rs2_used_ID && hz.rd_EX == hz.rs2_ID))) ||
                (ld_ex && cnt == CNT_WIDTH'(MAX_PENDING));
        ctrl.stall_pc_if = !rst && (waiting || (state == HZ_RUN && dep));
        ctrl.stall_if_id = ctrl.stall_pc_if;
        ctrl.flush_if_id = !rst && (state == HZ_IMEM_WAIT || state == HZ_REDIRECT || (state == HZ_RUN && redir));
        ctrl.flush_id_ex = !rst && (state == HZ_DMEM_WAIT || state == HZ_REDIRECT ||
                                    (state == HZ_RUN && (dep || redir)));
    end

    assign hz.stall_PC_IF = ctrl.stall_pc_if;
    assign hz.stall_IF_ID = ctrl.stall_if_id;
    assign hz.flush_IF_ID = ctrl.flush_if_id;
    assign hz.flush_ID_EX = ctrl.flush_id_ex;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(ctrl.stall_pc_if);
            flush_events <= flush_events + 32'(ctrl.flush_if_id | ctrl.flush_id_ex);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: queue-scoreboarded checks of the hazard scoreboard against a cycle model
module tb_hazard_scoreboard;
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] busy;
        logic [2:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [31:0] m_busy;
    int   m_cnt;
    int   m_st;
    bit   m_latch;

    hazard_scoreboard_if #(.AW(5), .CW(3)) bus ();

    hazard_scoreboard #(.REGISTER_ADDR_WIDTH(5), .MAX_PENDING(4)) dut (
        .clk(clk),
        .rst(rst),
        .hz(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.inst_mem_hazard = 0; bus.data_mem_hazard = 0;
        bus.rs1_ID = 0; bus.rs2_ID = 0; bus.rs1_used_ID = 0; bus.rs2_used_ID = 0;
        bus.rd_EX = 0; bus.result_sel_EX = 0;
        bus.load_issue_MEM = 0; bus.rd_MEM = 0; bus.load_done_WB = 0; bus.rd_WB = 0;
        bus.PC_take_branch_EX = 0; bus.PC_take_jalr_EX = 0;
    endtask

    function automatic logic [3:0] model_ctrl();
        bit ldex, dep, rd;
        ldex = bus.result_sel_EX == 2'b01;
        rd   = bus.PC_take_branch_EX || bus.PC_take_jalr_EX;
        dep  = (bus.rs1_used_ID && m_busy[bus.rs1_ID]) || (bus.rs2_used_ID && m_busy[bus.rs2_ID]) ||
               (ldex && bus.rd_EX != 0 && ((bus.rs1_used_ID && bus.rd_EX == bus.rs1_ID) ||
                                          (bus.rs2_used_ID && bus.rd_EX == bus.rs2_ID))) ||
               (ldex && m_cnt == 4);
        if (rst) return 4'b0000;
        case (m_st)
            1: return 4'b1110;
            2: return 4'b1101;
            3: return 4'b0011;
            default: return {dep, dep, rd, dep | rd};
        endcase
    endfunction

    task automatic model_update();
        bit rd;
        rd = bus.PC_take_branch_EX || bus.PC_take_jalr_EX;
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_st = 0; m_latch = 0;
            return;
        end
        if (bus.load_done_WB) m_busy[bus.rd_WB] = 1'b0;
        if (bus.load_issue_MEM && bus.rd_MEM != 0) m_busy[bus.rd_MEM] = 1'b1;
        if (bus.load_issue_MEM && !bus.load_done_WB && m_cnt < 4) m_cnt++;
        else if (bus.load_done_WB && !bus.load_issue_MEM && m_cnt > 0) m_cnt--;
        if ((m_st == 1 || m_st == 2) && rd) m_latch = 1;
        case (m_st)
            0: m_st = bus.data_mem_hazard ? 2 : bus.inst_mem_hazard ? 1 : 0;
            1: m_st = bus.data_mem_hazard ? 2 : bus.inst_mem_hazard ? 1 : m_latch ? 3 : 0;
            2: m_st = bus.data_mem_hazard ? 2 : m_latch ? 3 : 0;
            default: begin m_st = 0; m_latch = 0; end
        endcase
    endtask

    task automatic cmp();
        exp_t e;
        q.push_back('{ctrl: model_ctrl(), busy: m_busy, cnt: 3'(m_cnt)});
        #4;
        e = q.pop_front();
        check("ctrl", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, e.ctrl);
        check("busy", bus.busy_vec, e.busy);
        check("cnt", bus.pending_cnt, e.cnt);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cmp();
        tick();
    endtask

    initial begin
        idle();
        m_busy = 0; m_cnt = 0; m_st = 0; m_latch = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp();
        check("rst_ctrl", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 0);
        check("rst_busy", bus.busy_vec, 0);
        tick();
        rst = 0;
        step();

        bus.load_issue_MEM = 1; bus.rd_MEM = 5;
        step();
        idle(); bus.rs1_ID = 5; bus.rs1_used_ID = 1;
        for (int i = 0; i < 3; i++) begin
            cmp();
            check("dep_stall", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b1101);
            tick();
        end
        idle(); bus.load_done_WB = 1; bus.rd_WB = 5;
        step();
        idle(); bus.rs1_ID = 5; bus.rs1_used_ID = 1;
        cmp();
        check("dep_clear", bus.stall_PC_IF, 0);
        check("busy5_clear", bus.busy_vec[5], 0);
        tick();

        for (int r = 1; r <= 4; r++) begin
            idle(); bus.load_issue_MEM = 1; bus.rd_MEM = 5'(r);
            step();
        end
        idle(); bus.result_sel_EX = 2'b01; bus.rd_EX = 9; bus.load_issue_MEM = 1; bus.rd_MEM = 8;
        cmp();
        check("cap_cnt", bus.pending_cnt, 4);
        check("cap_stall", bus.stall_PC_IF, 1);
        tick();
        idle(); bus.result_sel_EX = 2'b01; bus.rd_EX = 9; bus.load_done_WB = 1; bus.rd_WB = 1;
        cmp();
        check("sat_cnt", bus.pending_cnt, 4);
        tick();
        idle(); bus.result_sel_EX = 2'b01; bus.rd_EX = 9;
        cmp();
        check("cap_cnt3", bus.pending_cnt, 3);
        check("cap_release", bus.stall_PC_IF, 0);
        tick();
        foreach (q[i]) check("q_leftover", 1, 0);
        for (int r = 0; r < 4; r++) begin
            idle(); bus.load_done_WB = 1; bus.rd_WB = (r == 3) ? 5'd8 : 5'(r + 2);
            step();
        end
        idle();
        cmp();
        check("underflow_cnt", bus.pending_cnt, 0);
        check("drain_busy", bus.busy_vec, 0);
        tick();

        for (int i = 0; i < 5; i++) begin
            idle(); bus.data_mem_hazard = 1; bus.PC_take_branch_EX = (i == 2);
            cmp();
            check("dwait_noflush", bus.flush_IF_ID, 0);
            tick();
        end
        idle();
        cmp();
        check("dwait_last", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b1101);
        tick();
        cmp();
        check("redirect", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b0011);
        tick();
        cmp();
        check("after_redirect", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b0000);
        tick();
        bus.data_mem_hazard = 1;
        step();
        idle();
        step();
        cmp();
        check("latch_cleared", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b0000);
        tick();

        bus.inst_mem_hazard = 1; bus.data_mem_hazard = 1;
        step();
        cmp();
        check("both_dmem", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b1101);
        tick();
        idle();
        step();
        bus.inst_mem_hazard = 1;
        step();
        cmp();
        check("imem_wait", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b1110);
        tick();
        idle();
        step();
        step();

        bus.result_sel_EX = 2'b01; bus.rd_EX = 6; bus.rs2_ID = 6; bus.rs2_used_ID = 1; bus.PC_take_jalr_EX = 1;
        cmp();
        check("redir_dep", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b1111);
        tick();

        idle(); bus.load_issue_MEM = 1; bus.rd_MEM = 7;
        step();
        bus.load_done_WB = 1; bus.rd_WB = 7;
        step();
        idle(); bus.load_issue_MEM = 1; bus.rd_MEM = 0;
        cmp();
        check("same_busy7", bus.busy_vec[7], 1);
        check("same_cnt", bus.pending_cnt, 1);
        tick();
        idle();
        cmp();
        check("x0_busy", bus.busy_vec[0], 0);
        check("x0_cnt", bus.pending_cnt, 2);
        tick();
        bus.load_issue_MEM = 1; bus.rd_MEM = 3;
        step();
        idle(); bus.data_mem_hazard = 1;
        step();
        bus.PC_take_branch_EX = 1;
        step();
        bus.PC_take_branch_EX = 0; rst = 1;
        cmp();
        check("rst_mid", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b0000);
        tick();
        rst = 0; idle();
        cmp();
        check("post_rst_ctrl", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b0000);
        check("post_rst_busy", bus.busy_vec, 0);
        check("post_rst_cnt", bus.pending_cnt, 0);
        tick();
        cmp();
        check("post_rst_run", {bus.stall_PC_IF, bus.stall_IF_ID, bus.flush_IF_ID, bus.flush_ID_EX}, 4'b0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the five-stage pipeline hazard unit. Adds a per-register busy scoreboard for multi-cycle loads and a pending-load counter with a depth limit.
- Adds a stall FSM for instruction-memory and data-memory waits. A branch or jalr redirect that arrives during a memory stall is latched and applied after the stall.
- Sits between the ID/EX/MEM/WB pipeline registers and the PC/IF control. Drives all stall and flush controls.

Parameters:
- REGISTER_ADDR_WIDTH, 5, register index width; the scoreboard holds 2**REGISTER_ADDR_WIDTH entries.
- MAX_PENDING, 4, maximum outstanding loads in flight (>=1).
- CNT_WIDTH, $clog2(MAX_PENDING+1), width of the pending-load counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- inst_mem_hazard  in  1  instruction fetch not ready this cycle
- data_mem_hazard  in  1  data memory not ready this cycle
- rs1_ID, rs2_ID  in  REGISTER_ADDR_WIDTH  ID source registers
- rs1_used_ID, rs2_used_ID  in  1  source actually read by the ID instruction
- rd_EX  in  REGISTER_ADDR_WIDTH  EX destination
- result_sel_EX  in  2  equal to `SEL_MEM_AS_RES marks a load in EX
- load_issue_MEM  in  1  a load enters MEM this cycle (request accepted)
- rd_MEM  in  REGISTER_ADDR_WIDTH  destination of the issuing load
- load_done_WB  in  1  load data written back this cycle
- rd_WB  in  REGISTER_ADDR_WIDTH  destination of the completing load
- PC_take_branch_EX, PC_take_jalr_EX  in  1  redirect requests
- stall_PC_IF, stall_IF_ID, flush_IF_ID, flush_ID_EX  out  1  pipeline controls
- busy_vec  out  2**REGISTER_ADDR_WIDTH  scoreboard state
- pending_cnt  out  CNT_WIDTH  outstanding loads

Behaviour:
- Reset: FSM=RUN, busy_vec=0, pending_cnt=0, redirect latch=0. All four control outputs are 0 during the reset cycle.
- Scoreboard:
  - load_issue_MEM with rd_MEM!=0 sets busy[rd_MEM].
  - load_done_WB clears busy[rd_WB].
  - If issue and done target the same register in the same cycle, set wins (newer load).
  - busy[0] is always 0.
- pending_cnt:
  - +1 on issue, -1 on done, unchanged when both occur.
  - Saturates at MAX_PENDING; never underflows (done at 0 is ignored).
- Combinational dependency stall (RUN only), dep = any of:
  - rs1_used_ID && busy[rs1_ID]
  - rs2_used_ID && busy[rs2_ID]
  - result_sel_EX==`SEL_MEM_AS_RES && rd_EX!=0 && rd_EX matches a used source
  - result_sel_EX==`SEL_MEM_AS_RES && pending_cnt==MAX_PENDING (capacity stall)
- When dep: stall_PC_IF=1, stall_IF_ID=1, flush_ID_EX=1.
- FSM states RUN, IMEM_WAIT, DMEM_WAIT, REDIRECT:
  - RUN: data_mem_hazard -> DMEM_WAIT; else inst_mem_hazard -> IMEM_WAIT. Both asserted: DMEM_WAIT has priority.
  - IMEM_WAIT: stall_PC_IF=1, stall_IF_ID=1, flush_IF_ID=1. Returns to RUN the cycle after inst_mem_hazard drops. data_mem_hazard arriving here -> DMEM_WAIT.
  - DMEM_WAIT: stall_PC_IF=1, stall_IF_ID=1, flush_ID_EX=1. Leaves the cycle after data_mem_hazard drops: to REDIRECT if the latch is set, else RUN.
  - REDIRECT: one cycle with flush_IF_ID=1, flush_ID_EX=1; clears the latch, then -> RUN.
- Redirect handling:
  - In RUN, a branch or jalr flushes IF_ID and ID_EX in the same cycle. It overrides the dependency stall's flush_ID_EX but not the stalls.
  - In any wait state, a branch or jalr sets the latch instead.
- The scoreboard and counter update in every state, including stalls.
- Reset asserted mid-stall returns to RUN with the latch cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined: adds 32-bit outputs stall_cycles and flush_events.
  - stall_cycles increments on every cycle with stall_PC_IF=1.
  - flush_events increments on every cycle with flush_IF_ID or flush_ID_EX set.
  - Both wrap on overflow; reset to 0.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- riscv_defs.vh: `SEL_MEM_AS_RES, plus FSM state encodings HZ_RUN/HZ_IMEM_WAIT/HZ_DMEM_WAIT/HZ_REDIRECT (2-bit).
- One natural sub-module: reg_scoreboard (busy vector plus pending counter, with set/clear/saturation). The parent holds the FSM and the output logic.

Test Plan:
- Load x5 issued, ID reads x5 (rs1_used=1) for 3 cycles before load_done_WB -> stall_PC_IF/stall_IF_ID/flush_ID_EX=1 for exactly those cycles; busy[5] clears on done.
- 4 loads issued with no done (MAX_PENDING=4), then a 5th load in EX -> pending_cnt=4 and capacity stall; one done -> pending_cnt=3, stall drops next cycle.
- data_mem_hazard held 5 cycles with a branch taken in cycle 2 -> no flush_IF_ID during the wait; one REDIRECT cycle with both flushes after release; latch cleared.
- inst_mem_hazard and data_mem_hazard asserted together -> FSM enters DMEM_WAIT; outputs match DMEM_WAIT.
- Same-cycle issue and done to x7 -> busy[7] stays 1, pending_cnt unchanged; issue to x0 -> busy[0]=0.
- rst asserted while in DMEM_WAIT with the latch set -> next cycle FSM=RUN, all outputs 0, busy_vec=0.
